// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg: shared types and constants for the stopwatch controller.
//   - sw_state_e : FSM state encoding (IDLE=0, RUN=1, PAUSE=2, LAP=3)
//   - SEG_*      : active-low 7-segment codes, bit order gfedcba
//   - AN_*       : active-low anode patterns, bit0 is the rightmost digit
//   - seg_encode / an_select : decode helpers used by the display path
package stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    LAP   = 2'd3
  } sw_state_e;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [3:0] AN_0   = 4'b1110;
  localparam logic [3:0] AN_1   = 4'b1101;
  localparam logic [3:0] AN_2   = 4'b1011;
  localparam logic [3:0] AN_3   = 4'b0111;
  localparam logic [3:0] AN_OFF = 4'b1111;

  // Non-BCD values fall back to the "0" glyph.
  function automatic logic [6:0] seg_encode(input logic [3:0] value);
    logic [6:0] seg;
    case (value)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_0;
    endcase
    return seg;
  endfunction

  function automatic logic [3:0] an_select(input logic [1:0] idx);
    logic [3:0] an;
    case (idx)
      2'd0:    an = AN_0;
      2'd1:    an = AN_1;
      2'd2:    an = AN_2;
      2'd3:    an = AN_3;
      default: an = AN_OFF;
    endcase
    return an;
  endfunction

endpackage

// File: rtl/stopwatch_ctrl_bcd_digit.sv
// sw_bcd_digit: one BCD digit (0..9) with clock enable and synchronous clear.
//   clk, rst : clock and synchronous active-high reset
//   clr      : synchronous clear, takes priority over en
//   en       : advance by one (9 wraps to 0)
//   digit    : current value
//   tc       : terminal count, high while digit == 9 (feeds the next stage)
module sw_bcd_digit (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       en,
  output logic [3:0] digit,
  output logic       tc
);

  logic [3:0] digit_q;
  logic [3:0] digit_d;

  // Next-value logic: clear wins, otherwise count with 9 -> 0 wrap.
  always_comb begin
    digit_d = digit_q;
    if (clr) begin
      digit_d = 4'd0;
    end else if (en) begin
      digit_d = (digit_q == 4'd9) ? 4'd0 : (digit_q + 4'd1);
    end else begin
      digit_d = digit_q;
    end
  end

  // Digit register.
  always_ff @(posedge clk) begin
    if (rst) begin
      digit_q <= 4'd0;
    end else begin
      digit_q <= digit_d;
    end
  end

  assign digit = digit_q;
  assign tc    = (digit_q == 4'd9);

endmodule

// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: 4-digit 0.01 s stopwatch with multiplexed 7-segment output.
//   clk, rst  : single clock, synchronous active-high reset
//   btn_ss    : start/stop level    btn_lap : lap level    btn_clr : clear level
//   D0_SEG    : active-low segments gfedcba
//   D0_AN     : active-low anodes, bit0 rightmost
//   D0_DP     : active-low decimal point (lit between seconds and hundredths)
//   state     : FSM state for LEDs    ovf : sticky 99.99 -> 00.00 wrap flag
// Build option: define STOPWATCH_LZB_EN to blank the leftmost digit when it is 0.
// All registers run on clk; the count and scan rates come from enable prescalers.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int TICK_DIV = 1000000,
  parameter int SCAN_DIV = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_ss,
  input  logic       btn_lap,
  input  logic       btn_clr,
  output logic [6:0] D0_SEG,
  output logic [3:0] D0_AN,
  output logic       D0_DP,
  output logic [1:0] state,
  output logic       ovf
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);

  // Button vectors are ordered {clr, ss, lap}, matching press priority.
  logic [2:0]    btn_prev_q, btn_prev_d, press_s;
  sw_state_e     state_q, state_d;
  logic          clear_s, capture_s, counting_s, tick_s;
  logic [TW-1:0] tick_cnt_q, tick_cnt_d;
  logic [SW-1:0] scan_cnt_q, scan_cnt_d;
  logic [1:0]    scan_idx_q, scan_idx_d;
  logic [15:0]   lap_q, lap_d, count_s, disp_s;
  logic          ovf_q, ovf_d;
  logic [3:0]    tc_s, digit_s;
  logic [3:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;

  assign btn_prev_d = {btn_clr, btn_ss, btn_lap};
  assign press_s    = btn_prev_d & ~btn_prev_q;

  // Next-state decode; clear paths also zero count, lap, ovf and tick prescaler.
  always_comb begin
    state_d   = state_q;
    clear_s   = 1'b0;
    capture_s = 1'b0;
    if (press_s[2]) begin
      state_d = IDLE;
      clear_s = 1'b1;
    end else if (press_s[1]) begin
      case (state_q)
        IDLE:    state_d = RUN;
        RUN:     state_d = PAUSE;
        PAUSE:   state_d = RUN;
        LAP:     state_d = PAUSE;
        default: state_d = IDLE;
      endcase
    end else if (press_s[0]) begin
      case (state_q)
        RUN: begin
          state_d   = LAP;
          capture_s = 1'b1;
        end
        LAP:     state_d = RUN;
        PAUSE: begin
          state_d = IDLE;
          clear_s = 1'b1;
        end
        IDLE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // Tick prescaler: runs in RUN/LAP, holds in PAUSE, zero in IDLE.
  // Enables use state_q so a tick coinciding with a stop press still counts.
  assign counting_s = (state_q == RUN) || (state_q == LAP);
  assign tick_s     = counting_s && (tick_cnt_q == TICK_LAST);

  always_comb begin
    tick_cnt_d = tick_cnt_q;
    if (clear_s || (state_q == IDLE)) begin
      tick_cnt_d = '0;
    end else if (tick_s) begin
      tick_cnt_d = '0;
    end else if (counting_s) begin
      tick_cnt_d = tick_cnt_q + TW'(1);
    end else begin
      tick_cnt_d = tick_cnt_q;
    end
  end

  // Four-digit cascade: a digit advances when every lower digit is at 9.
  sw_bcd_digit u_d0 (.clk(clk), .rst(rst), .clr(clear_s), .en(tick_s),
                     .digit(count_s[3:0]),   .tc(tc_s[0]));
  sw_bcd_digit u_d1 (.clk(clk), .rst(rst), .clr(clear_s), .en(tick_s & tc_s[0]),
                     .digit(count_s[7:4]),   .tc(tc_s[1]));
  sw_bcd_digit u_d2 (.clk(clk), .rst(rst), .clr(clear_s), .en(tick_s & (&tc_s[1:0])),
                     .digit(count_s[11:8]),  .tc(tc_s[2]));
  sw_bcd_digit u_d3 (.clk(clk), .rst(rst), .clr(clear_s), .en(tick_s & (&tc_s[2:0])),
                     .digit(count_s[15:12]), .tc(tc_s[3]));

  // Lap capture takes the registered (pre-increment) count; ovf is sticky.
  always_comb begin
    lap_d = lap_q;
    ovf_d = ovf_q;
    if (clear_s) begin
      lap_d = 16'h0000;
      ovf_d = 1'b0;
    end else begin
      lap_d = capture_s ? count_s : lap_q;
      ovf_d = ovf_q | (tick_s & (&tc_s));
    end
  end

  // Scan prescaler and digit index, free-running in every state.
  always_comb begin
    scan_cnt_d = scan_cnt_q;
    scan_idx_d = scan_idx_q;
    if (scan_cnt_q == SCAN_LAST) begin
      scan_cnt_d = '0;
      scan_idx_d = scan_idx_q + 2'd1;
    end else begin
      scan_cnt_d = scan_cnt_q + SW'(1);
      scan_idx_d = scan_idx_q;
    end
  end

  // Display source selection and per-digit segment/anode/DP decode.
  assign disp_s = (state_q == LAP) ? lap_q : count_s;

  always_comb begin
    case (scan_idx_q)
      2'd0:    digit_s = disp_s[3:0];
      2'd1:    digit_s = disp_s[7:4];
      2'd2:    digit_s = disp_s[11:8];
      2'd3:    digit_s = disp_s[15:12];
      default: digit_s = 4'd0;
    endcase
    an_d  = an_select(scan_idx_q);
    dp_d  = (scan_idx_q == 2'd2) ? 1'b0 : 1'b1;
    seg_d = seg_encode(digit_s);
`ifdef STOPWATCH_LZB_EN
    if ((scan_idx_q == 2'd3) && (digit_s == 4'd0)) begin
      seg_d = SEG_BLANK;
    end else begin
      seg_d = seg_encode(digit_s);
    end
`else
    seg_d = seg_encode(digit_s);
`endif
  end

  // All controller state and registered display outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      btn_prev_q <= 3'b111;
      state_q    <= IDLE;
      tick_cnt_q <= '0;
      scan_cnt_q <= '0;
      scan_idx_q <= 2'd0;
      lap_q      <= 16'h0000;
      ovf_q      <= 1'b0;
      an_q       <= AN_OFF;
      seg_q      <= SEG_BLANK;
      dp_q       <= 1'b1;
    end else begin
      btn_prev_q <= btn_prev_d;
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      scan_cnt_q <= scan_cnt_d;
      scan_idx_q <= scan_idx_d;
      lap_q      <= lap_d;
      ovf_q      <= ovf_d;
      an_q       <= an_d;
      seg_q      <= seg_d;
      dp_q       <= dp_d;
    end
  end

  assign D0_SEG = seg_q;
  assign D0_AN  = an_q;
  assign D0_DP  = dp_q;
  assign state  = state_q;
  assign ovf    = ovf_q;

endmodule
